// File: rtl/ulpi_link_ctrl.sv
// ulpi_link_ctrl: ULPI link front end covering bus turnaround, RX CMD/data decode and PHY register access.
module ulpi_link_ctrl #(
  parameter int NXT_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] ulpi_data_out_i,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic [7:0] ulpi_data_in_o,
  output logic       ulpi_stp_o,
  input  logic       reg_req_i,
  input  logic       reg_we_i,
  input  logic [5:0] reg_addr_i,
  input  logic [7:0] reg_wdata_i,
  output logic       reg_ack_o,
  output logic       reg_abort_o,
  output logic [7:0] reg_rdata_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_active_o,
  output logic       rx_error_o,
  output logic [1:0] linestate_o
);
  localparam int CW = $clog2(NXT_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CMD, WDATA, STP, RTURN, RDATA, RBACK} state_t;
  state_t r_state, w_next;
  logic r_dir_q, r_dir_qq, r_nxt_q;
  logic [7:0] r_data_q;
  logic r_we, r_abt;
  logic [5:0] r_addr;
  logic [7:0] r_wdata, r_rdata, r_rx_data;
  logic [CW-1:0] r_cnt;
  logic r_rx_valid, r_rx_active, r_rx_error;
  logic [1:0] r_linestate;
  logic w_turn, w_busy, w_tmo, w_latch, w_cnt_clr, w_abt, w_cap, w_rx_en;
  assign w_turn = r_dir_q != r_dir_qq;
  assign w_busy = r_dir_q || w_turn;
  assign w_tmo = r_cnt == CW'(NXT_TIMEOUT - 1);
  // The register read data phase belongs to the FSM, not to the RX decoder.
  assign w_rx_en = r_dir_q && !w_turn && r_state != RDATA && r_state != RBACK;
  always_comb begin
    w_next = r_state;
    w_latch = 1'b0;
    w_cnt_clr = 1'b0;
    w_abt = 1'b0;
    w_cap = 1'b0;
    case (r_state)
      IDLE: if (reg_req_i && !w_busy) begin
        w_next = CMD;
        w_latch = 1'b1;
        w_cnt_clr = 1'b1;
      end
      CMD: if (w_busy) w_cnt_clr = 1'b1;
        else if (r_nxt_q) begin
          w_next = r_we ? WDATA : RTURN;
          w_cnt_clr = 1'b1;
        end else if (w_tmo) begin
          w_next = STP;
          w_abt = 1'b1;
        end
      WDATA: if (w_busy) begin
          w_next = CMD;
          w_cnt_clr = 1'b1;
        end else if (r_nxt_q) w_next = STP;
        else if (w_tmo) begin
          w_next = STP;
          w_abt = 1'b1;
        end
      STP: w_next = IDLE;
      RTURN: if (r_dir_q) w_next = RDATA;
      RDATA: begin
        w_next = RBACK;
        w_cap = 1'b1;
      end
      RBACK: if (!r_dir_q) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_dir_q <= 1'b0;
      r_dir_qq <= 1'b0;
      r_nxt_q <= 1'b0;
      r_data_q <= 8'h00;
      r_we <= 1'b0;
      r_addr <= 6'h00;
      r_wdata <= 8'h00;
      r_cnt <= '0;
      r_abt <= 1'b0;
      r_rdata <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_data <= 8'h00;
      r_rx_active <= 1'b0;
      r_rx_error <= 1'b0;
      r_linestate <= 2'b00;
    end else begin
      r_state <= w_next;
      r_dir_q <= ulpi_dir_i;
      r_dir_qq <= r_dir_q;
      r_nxt_q <= ulpi_nxt_i;
      r_data_q <= ulpi_data_out_i;
      if (w_latch) {r_we, r_addr, r_wdata} <= {reg_we_i, reg_addr_i, reg_wdata_i};
      r_cnt <= w_cnt_clr ? '0 : (r_state == CMD || r_state == WDATA) ? r_cnt + 1'b1 : r_cnt;
      r_abt <= w_abt;
      if (w_cap) r_rdata <= r_data_q;
      r_rx_valid <= w_rx_en && r_nxt_q;
      if (w_rx_en && r_nxt_q) r_rx_data <= r_data_q;
      if (w_rx_en && !r_nxt_q) begin
        r_linestate <= r_data_q[1:0];
        r_rx_active <= r_data_q[4];
        r_rx_error <= r_data_q[5] && r_data_q[4];
      end else if (w_turn && r_dir_q && r_nxt_q) r_rx_active <= 1'b1;
      else if (w_turn && !r_dir_q) r_rx_active <= 1'b0;
    end
  end
  assign ulpi_data_in_o = w_busy ? 8'h00 :
                          r_state == CMD ? {r_we ? 2'b10 : 2'b11, r_addr} :
                          r_state == WDATA ? r_wdata : 8'h00;
  assign ulpi_stp_o = r_state == STP && !r_dir_q;
  assign reg_ack_o = (r_state == STP && !r_abt) || (r_state == RBACK && !r_dir_q);
  assign reg_abort_o = r_state == STP && r_abt;
  assign reg_rdata_o = r_rdata;
  assign rx_valid_o = r_rx_valid;
  assign rx_data_o = r_rx_data;
  assign rx_active_o = r_rx_active;
  assign rx_error_o = r_rx_error;
  assign linestate_o = r_linestate;
endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// tb_ulpi_link_ctrl: directed PHY-side stimulus with hand-computed expectations for ulpi_link_ctrl.
module tb_ulpi_link_ctrl;
  logic clk = 1'b0;
  logic rst, dir, nxt, stp, req, we, ack, abt, rxv, rxa, rxe;
  logic [7:0] d_out, d_in, wdata, rdata, rxd;
  logic [5:0] addr;
  logic [1:0] ls;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ulpi_link_ctrl #(.NXT_TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst), .ulpi_data_out_i(d_out), .ulpi_dir_i(dir), .ulpi_nxt_i(nxt),
    .ulpi_data_in_o(d_in), .ulpi_stp_o(stp), .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr),
    .reg_wdata_i(wdata), .reg_ack_o(ack), .reg_abort_o(abt), .reg_rdata_o(rdata),
    .rx_valid_o(rxv), .rx_data_o(rxd), .rx_active_o(rxa), .rx_error_o(rxe), .linestate_o(ls)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick; chk("wr_txcmd", d_in, {2'b10, a}); chk("wr_stp_lo", stp, 0);
    tick; chk("wr_txcmd_hold", d_in, {2'b10, a}); nxt = 1'b1;
    tick; chk("wr_txcmd_hold2", d_in, {2'b10, a});
    tick; chk("wr_data", d_in, d); chk("wr_ack_early", ack, 0); nxt = 1'b0;
    tick; chk("wr_stp", stp, 1); chk("wr_ack", ack, 1); chk("wr_stp_data", d_in, 8'h00); chk("wr_abort", abt, 0);
    req = 1'b0;
    tick; chk("wr_stp_end", stp, 0); chk("wr_ack_end", ack, 0);
  endtask
  initial begin
    rst = 1'b1; dir = 1'b0; nxt = 1'b0; d_out = 8'h00;
    req = 1'b0; we = 1'b0; addr = 6'h00; wdata = 8'h00;
    tick; tick;
    chk("rst_data", d_in, 8'h00); chk("rst_stp", stp, 0); chk("rst_ack", ack, 0);
    chk("rst_abort", abt, 0); chk("rst_rdata", rdata, 8'h00); chk("rst_rxv", rxv, 0);
    chk("rst_rxd", rxd, 8'h00); chk("rst_rxa", rxa, 0); chk("rst_rxe", rxe, 0); chk("rst_ls", ls, 0);
    rst = 1'b0;
    do_write(6'h0A, 8'h55);
    // register read of 0x16 returning 0xA5
    req = 1'b1; we = 1'b0; addr = 6'h16;
    tick; chk("rd_txcmd", d_in, 8'hD6); nxt = 1'b1;
    tick; chk("rd_txcmd_hold", d_in, 8'hD6);
    tick; chk("rd_turn_data", d_in, 8'h00); nxt = 1'b0; dir = 1'b1;
    tick; chk("rd_dir_data", d_in, 8'h00); d_out = 8'hA5;
    tick; chk("rd_ack_early", ack, 0); dir = 1'b0; d_out = 8'h00;
    tick; chk("rd_ack", ack, 1); chk("rd_rdata", rdata, 8'hA5); req = 1'b0;
    tick; chk("rd_ack_end", ack, 0); chk("rd_rdata_hold", rdata, 8'hA5);
    chk("rd_no_rxcmd_ls", ls, 0); chk("rd_no_rxcmd_err", rxe, 0); chk("rd_no_rxv", rxv, 0);
    // RX CMD decode
    dir = 1'b1; nxt = 1'b0; d_out = 8'h1D;
    tick;
    tick; chk("rxcmd_turn_ls", ls, 0); chk("rxcmd_turn_act", rxa, 0);
    tick; chk("rxcmd_ls", ls, 2'b01); chk("rxcmd_act", rxa, 1); chk("rxcmd_err", rxe, 0); chk("rxcmd_rxv", rxv, 0);
    d_out = 8'h3E;
    tick;
    tick; chk("rxcmd2_ls", ls, 2'b10); chk("rxcmd2_act", rxa, 1); chk("rxcmd2_err", rxe, 1);
    dir = 1'b0; d_out = 8'h00;
    tick;
    tick; chk("rxcmd_dirfall_act", rxa, 0); chk("rxcmd_dirfall_rxv", rxv, 0);
    // RX packet burst starting with dir and nxt together
    dir = 1'b1; nxt = 1'b1; d_out = 8'h00;
    tick; d_out = 8'hB0;
    tick; chk("burst_turn_act", rxa, 1); chk("burst_turn_rxv", rxv, 0); d_out = 8'hB1;
    tick; chk("burst_v0", rxv, 1); chk("burst_d0", rxd, 8'hB0); d_out = 8'hB2;
    tick; chk("burst_v1", rxv, 1); chk("burst_d1", rxd, 8'hB1); dir = 1'b0; nxt = 1'b0; d_out = 8'h00;
    tick; chk("burst_v2", rxv, 1); chk("burst_d2", rxd, 8'hB2);
    tick; chk("burst_end_v", rxv, 0); chk("burst_end_act", rxa, 0);
    // PHY grabs the bus while a write TXCMD waits for nxt
    req = 1'b1; we = 1'b1; addr = 6'h03; wdata = 8'h3C;
    tick; chk("ab_txcmd", d_in, 8'h83); dir = 1'b1; nxt = 1'b0; d_out = 8'h1D;
    tick; chk("ab_release", d_in, 8'h00); chk("ab_stp", stp, 0);
    tick;
    tick; chk("ab_rx_ls", ls, 2'b01); chk("ab_rx_act", rxa, 1); dir = 1'b0; d_out = 8'h00;
    tick; chk("ab_turn_data", d_in, 8'h00);
    tick; chk("ab_reissue", d_in, 8'h83); chk("ab_act_clr", rxa, 0); nxt = 1'b1;
    tick; chk("ab_reissue_hold", d_in, 8'h83);
    tick; chk("ab_wdata", d_in, 8'h3C); chk("ab_ack_early", ack, 0); nxt = 1'b0;
    tick; chk("ab_stp_pulse", stp, 1); chk("ab_ack", ack, 1); req = 1'b0;
    tick; chk("ab_ack_end", ack, 0); chk("ab_stp_end", stp, 0);
    // nxt never arrives
    req = 1'b1; we = 1'b1; addr = 6'h2A; wdata = 8'h11;
    tick; chk("to_txcmd", d_in, 8'hAA);
    repeat (7) tick;
    chk("to_wait_data", d_in, 8'hAA); chk("to_wait_stp", stp, 0); chk("to_wait_abort", abt, 0);
    tick; chk("to_abort", abt, 1); chk("to_stp", stp, 1); chk("to_no_ack", ack, 0); chk("to_data", d_in, 8'h00);
    req = 1'b0;
    tick; chk("to_abort_end", abt, 0); chk("to_stp_end", stp, 0); chk("to_idle_data", d_in, 8'h00);
    do_write(6'h0A, 8'h55);
    // reset in the middle of a write
    req = 1'b1; we = 1'b1; addr = 6'h01; wdata = 8'h77;
    tick; chk("mr_txcmd", d_in, 8'h81); rst = 1'b1;
    tick; chk("mr_data", d_in, 8'h00); chk("mr_stp", stp, 0); chk("mr_ack", ack, 0);
    chk("mr_abort", abt, 0); chk("mr_ls", ls, 0); chk("mr_rdata", rdata, 8'h00);
    rst = 1'b0; req = 1'b0;
    tick; chk("mr_idle_data", d_in, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
